// File: rtl/signal_frame_fifo.sv
// Circular signal-word buffer with end-of-frame tagging feeding the Taylor MAC.
// Latency: read data registered, valid one cycle after an accepted rd_en_i; all flags registered-state derived.
// Backpressure: writes while full are dropped (drop_o pulse next cycle); reads while empty are ignored.
module signal_frame_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  output logic                  full_o,
  output logic                  drop_o,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  empty_o,
  output logic [ADDR_LINES:0]   count_o,
  output logic                  frame_ready_o
);

  localparam int DEPTH = 2 ** ADDR_LINES;

  // Storage entry is {last, data}; the last tag lives in the top bit.
  logic [DATA_WIDTH:0]   r_mem [DEPTH];
  logic [ADDR_LINES:0]   r_wr_ptr;
  logic [ADDR_LINES:0]   r_rd_ptr;
  logic [ADDR_LINES:0]   r_frame_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic                  r_drop;
  logic                  r_frame_ready;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [DATA_WIDTH:0]   w_rd_entry;
  logic                  w_frame_inc;
  logic                  w_frame_dec;
  logic [ADDR_LINES:0]   w_one;
  logic [ADDR_LINES:0]   w_frame_cnt_nxt;

  assign w_one      = {{ADDR_LINES{1'b0}}, 1'b1};

  // Pointer MSB is the wrap parity: equal low bits with differing parity means full.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[ADDR_LINES-1:0] == r_rd_ptr[ADDR_LINES-1:0]) &&
                      (r_wr_ptr[ADDR_LINES] != r_rd_ptr[ADDR_LINES]);
  assign w_wr_ok    = wr_en_i && !w_full;
  assign w_rd_ok    = rd_en_i && !w_empty;
  assign w_rd_entry = r_mem[r_rd_ptr[ADDR_LINES-1:0]];

  assign w_frame_inc = w_wr_ok && last_i;
  assign w_frame_dec = w_rd_ok && w_rd_entry[DATA_WIDTH];

  // Frame counter next value: a frame entering and one leaving in the same cycle cancel out.
  always_comb begin
    w_frame_cnt_nxt = r_frame_cnt;
    if (w_frame_inc && !w_frame_dec) begin
      w_frame_cnt_nxt = r_frame_cnt + w_one;
    end else if (w_frame_dec && !w_frame_inc) begin
      w_frame_cnt_nxt = r_frame_cnt - w_one;
    end
  end

  // Storage array write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_wr_ok) begin
      r_mem[r_wr_ptr[ADDR_LINES-1:0]] <= {last_i, data_i};
    end
  end

  // Pointers, read data register, drop pulse and frame tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_frame_cnt   <= '0;
      r_data        <= '0;
      r_last        <= 1'b0;
      r_drop        <= 1'b0;
      r_frame_ready <= 1'b0;
    end else begin
      r_drop        <= wr_en_i && w_full;
      r_frame_cnt   <= w_frame_cnt_nxt;
      // Registered from the next count so the flag lines up with count_o/empty_o.
      r_frame_ready <= (w_frame_cnt_nxt != '0);
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + w_one;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + w_one;
        r_data   <= w_rd_entry[DATA_WIDTH-1:0];
        r_last   <= w_rd_entry[DATA_WIDTH];
      end
    end
  end

  assign full_o        = w_full;
  assign empty_o       = w_empty;
  assign count_o       = r_wr_ptr - r_rd_ptr;
  assign drop_o        = r_drop;
  assign data_o        = r_data;
  assign last_o        = r_last;
  assign frame_ready_o = r_frame_ready;

endmodule

// File: tb/tb_signal_frame_fifo.sv
module tb_signal_frame_fifo;

  localparam int DW    = 32;
  localparam int AL    = 5;
  localparam int DEPTH = 2 ** AL;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          last_in = 1'b0;
  logic          rd_en = 1'b0;
  logic          full;
  logic          drop;
  logic [DW-1:0] data_out;
  logic          last_out;
  logic          empty;
  logic [AL:0]   count;
  logic          frame_ready;

  int n_total = 0;
  int n_pass  = 0;

  signal_frame_fifo #(.DATA_WIDTH(DW), .ADDR_LINES(AL)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .data_i(data_in), .last_i(last_in),
    .full_o(full), .drop_o(drop), .rd_en_i(rd_en), .data_o(data_out), .last_o(last_out),
    .empty_o(empty), .count_o(count), .frame_ready_o(frame_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model: a queue of {last,data} ----------------
  logic [DW:0]   mq[$];
  logic [DW:0]   m_ent;
  logic [DW-1:0] m_data = '0;
  logic          m_last = 1'b0;
  logic          m_drop = 1'b0;
  bit            m_valid = 0;
  bit            m_was_full, m_was_empty;

  function automatic bit m_has_frame();
    foreach (mq[i]) if (mq[i][DW]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_data  = '0;
      m_last  = 1'b0;
      m_drop  = 1'b0;
      m_valid = 1;
    end else begin
      m_was_full  = (mq.size() == DEPTH);
      m_was_empty = (mq.size() == 0);
      m_drop = wr_en && m_was_full;
      if (rd_en && !m_was_empty) begin
        m_ent  = mq.pop_front();
        m_last = m_ent[DW];
        m_data = m_ent[DW-1:0];
      end
      if (wr_en && !m_was_full) mq.push_back({last_in, data_in});
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_empty", 64'(empty), 64'(mq.size() == 0));
      chk("m_full", 64'(full), 64'(mq.size() == DEPTH));
      chk("m_drop", 64'(drop), 64'(m_drop));
      chk("m_data", 64'(data_out), 64'(m_data));
      chk("m_last", 64'(last_out), 64'(m_last));
      chk("m_frame_ready", 64'(frame_ready), 64'(m_has_frame()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic wr, input logic [DW-1:0] d, input logic l,
                      input logic rd, input logic r);
    wr_en = wr; data_in = d; last_in = l; rd_en = rd; rst = r;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; rst = 1'b0; last_in = 1'b0;
  endtask

  task automatic wr1(input logic [DW-1:0] d, input logic l);
    step(1'b1, d, l, 1'b0, 1'b0);
  endtask

  task automatic rd1();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);

    // 1. three-word frame
    wr1(32'h3F800000, 1'b0);
    chk("t1_fr_after_w1", 64'(frame_ready), 64'd0);
    wr1(32'h40000000, 1'b0);
    chk("t1_fr_after_w2", 64'(frame_ready), 64'd0);
    wr1(32'h40400000, 1'b1);
    chk("t1_count", 64'(count), 64'd3);
    chk("t1_empty", 64'(empty), 64'd0);
    chk("t1_fr", 64'(frame_ready), 64'd1);
    rd1();
    chk("t1_d0", 64'(data_out), 64'h3F800000);
    chk("t1_l0", 64'(last_out), 64'd0);
    rd1();
    chk("t1_d1", 64'(data_out), 64'h40000000);
    rd1();
    chk("t1_d2", 64'(data_out), 64'h40400000);
    chk("t1_l2", 64'(last_out), 64'd1);
    chk("t1_empty_end", 64'(empty), 64'd1);
    chk("t1_fr_end", 64'(frame_ready), 64'd0);

    // 2. fill and overflow
    for (int i = 0; i < DEPTH; i++) wr1(32'(i), 1'b0);
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_count", 64'(count), 64'd32);
    wr1(32'hDEAD0000, 1'b0);
    chk("t2_drop", 64'(drop), 64'd1);
    chk("t2_count_drop", 64'(count), 64'd32);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t2_drop_once", 64'(drop), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      rd1();
      chk("t2_drain", 64'(data_out), 64'(i));
    end
    chk("t2_empty", 64'(empty), 64'd1);

    // 3. steady-state rd+wr across pointer wrap
    for (int i = 0; i < 4; i++) wr1(32'(100 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 32'(104 + i), 1'b0, 1'b1, 1'b0);
      chk("t3_count", 64'(count), 64'd4);
      chk("t3_data", 64'(data_out), 64'(100 + i));
    end
    for (int i = 0; i < 4; i++) rd1();
    chk("t3_tail", 64'(data_out), 64'd143);

    // 4. reads on empty, then rd+wr while empty
    for (int i = 0; i < 3; i++) begin
      rd1();
      chk("t4_hold_data", 64'(data_out), 64'd143);
      chk("t4_hold_last", 64'(last_out), 64'd0);
      chk("t4_count", 64'(count), 64'd0);
    end
    step(1'b1, 32'hCAFE0001, 1'b0, 1'b1, 1'b0);
    chk("t4_count_rw", 64'(count), 64'd1);
    chk("t4_empty_rw", 64'(empty), 64'd0);
    chk("t4_data_unch", 64'(data_out), 64'd143);
    rd1();
    chk("t4_read_back", 64'(data_out), 64'hCAFE0001);

    // 5. frame counter with simultaneous frame in/out
    wr1(32'hA, 1'b0);
    wr1(32'hB, 1'b1);
    wr1(32'hC, 1'b0);
    wr1(32'hD, 1'b1);
    rd1();
    chk("t5_dA", 64'(data_out), 64'hA);
    step(1'b1, 32'hE, 1'b1, 1'b1, 1'b0);
    chk("t5_dB", 64'(data_out), 64'hB);
    chk("t5_lB", 64'(last_out), 64'd1);
    chk("t5_fr_stay", 64'(frame_ready), 64'd1);
    rd1();
    rd1();
    chk("t5_dD", 64'(data_out), 64'hD);
    chk("t5_fr_after_f2", 64'(frame_ready), 64'd1);
    rd1();
    chk("t5_dE", 64'(data_out), 64'hE);
    chk("t5_fr_after_f3", 64'(frame_ready), 64'd0);

    // 6. reset mid-frame with a concurrent write
    for (int i = 0; i < 7; i++) wr1(32'(200 + i), (i == 2));
    chk("t6_count7", 64'(count), 64'd7);
    step(1'b1, 32'h55, 1'b1, 1'b0, 1'b1);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_empty", 64'(empty), 64'd1);
    chk("t6_full", 64'(full), 64'd0);
    chk("t6_drop", 64'(drop), 64'd0);
    chk("t6_data", 64'(data_out), 64'd0);
    chk("t6_last", 64'(last_out), 64'd0);
    chk("t6_fr", 64'(frame_ready), 64'd0);
    wr1(32'h12345678, 1'b0);
    chk("t6_fr_partial", 64'(frame_ready), 64'd0);
    rd1();
    chk("t6_read", 64'(data_out), 64'h12345678);
    chk("t6_empty_end", 64'(empty), 64'd1);

    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
